// File: rtl/iter_mantissa_multiplier.sv
// Iterative shift-add unsigned mantissa multiplier: STEP multiplier bits retired per cycle, 2*WIDTH-bit product.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module iter_mantissa_multiplier #(
  parameter int WIDTH = 24,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int L     = WIDTH / STEP;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(L + 1);

  generate
    if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_param
      $error("iter_mantissa_multiplier: WIDTH must be >= 2 and a multiple of STEP");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [PW-1:0]      a_sh_q;
  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      result_q;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [PW-1:0]      pp;
  logic [PW-1:0]      acc_d;
  logic [WIDTH-1:0]   b_d;
  logic               last_iter;
  logic               accept;

  // The multiplicand is kept pre-shifted, so the partial product is already aligned to acc.
  always_comb begin
    pp    = a_sh_q * PW'(b_q[STEP-1:0]);
    acc_d = acc_q + pp;
    b_d   = b_q >> STEP;
`ifdef MULT_EARLY_EXIT_EN
    last_iter = (cnt_q == CNT_W'(L - 1)) || (b_d == '0);
`else
    last_iter = (cnt_q == CNT_W'(L - 1));
`endif
  end

  // out_ready feeds in_ready combinationally in DONE so a retiring result can admit the next pair.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh_q  <= PW'(a);
            b_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q  <= acc_d;
          a_sh_q <= a_sh_q << STEP;
          b_q    <= b_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              a_sh_q  <= PW'(a);
              b_q     <= b;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mantissa_multiplier.sv
// Directed bench for iter_mantissa_multiplier: a STEP=1 and a STEP=4 instance share all inputs.
module tb_iter_mantissa_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] a = '0;
  logic [23:0] b = '0;

  logic        in_ready1, out_valid1, busy1;
  logic [47:0] result1;
  logic        in_ready4, out_valid4, busy4;
  logic [47:0] result4;

  int n_tests = 0;
  int n_fail  = 0;

  iter_mantissa_multiplier #(.WIDTH(24), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .busy(busy1)
  );

  iter_mantissa_multiplier #(.WIDTH(24), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [23:0] v, input int step);
    int m = 0;
    for (int i = 0; i < 24; i++) if (v[i]) m = i + 1;
`ifdef MULT_EARLY_EXIT_EN
    if (m == 0) return 1;
    return (m + step - 1) / step;
`else
    return (m >= 0) ? 24 / step : 0;
`endif
  endfunction

  // Entered and left just after a rising edge with both instances idle.
  task automatic transact(input logic [23:0] ta, input logic [23:0] tb_, input logic [47:0] exp,
                          input string tag);
    int l1 = 0;
    int l4 = 0;
    a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_;
    for (int c = 1; c <= 60 && (l1 == 0 || l4 == 0); c++) begin
      @(posedge clk); #1;
      if (out_valid1 && l1 == 0) l1 = c;
      if (out_valid4 && l4 == 0) l4 = c;
    end
    chk({tag, " lat s1"}, l1, exp_lat(tb_, 1));
    chk({tag, " lat s4"}, l4, exp_lat(tb_, 4));
    chk({tag, " result s1"}, result1, exp);
    chk({tag, " result s4"}, result4, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " retire s1"}, {in_ready1, out_valid1}, 2'b10);
    chk({tag, " retire s4"}, {in_ready4, out_valid4}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] ra, rb;
    logic [23:0] pa [3];
    logic [23:0] pb [3];
    logic [47:0] pe [3];
    int idx, prev, got;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {out_valid1, out_valid4}, 2'b00);
    chk("reset busy", {busy1, busy4}, 2'b00);
    chk("reset result s1", result1, 48'h0);
    chk("reset result s4", result4, 48'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset in_ready", {in_ready1, in_ready4}, 2'b11);

    // Directed products
    transact(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max*max");
    transact(24'h800000, 24'h000003, 48'h000001800000, "msb*3");
    transact(24'hABCDEF, 24'h000001, 48'h000000ABCDEF, "b=1");
    transact(24'hABCDEF, 24'h000000, 48'h000000000000, "b=0");
    transact(24'h000002, 24'h000003, 48'h000000000006, "2*3");
    transact(24'h800000, 24'h800000, 48'h400000000000, "msb*msb");
    transact(24'h001000, 24'h001000, 48'h000001000000, "pow2");
    transact(24'h000000, 24'hFFFFFF, 48'h000000000000, "a=0");

    // Random sweep against the a*b reference
    for (int i = 0; i < 20; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      transact(ra, rb, 48'(ra) * 48'(rb), $sformatf("rand%0d", i));
    end

    // Backpressure: result held while out_ready is low, new operands refused
    a = 24'd5; b = 24'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && got == 0; c++) begin
      @(posedge clk); #1;
      if (out_valid1) got = 1;
    end
    chk("bp done reached", got, 1);
    a = 24'h111111; b = 24'h222222; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp hold valid", {out_valid1, out_valid4}, 2'b11);
      chk("bp hold result s1", result1, 48'd35);
      chk("bp hold result s4", result4, 48'd35);
      chk("bp hold in_ready", {in_ready1, in_ready4}, 2'b00);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp retire valid", {out_valid1, out_valid4}, 2'b00);
    chk("bp retire busy", {busy1, busy4}, 2'b00);
    chk("bp result kept", result1, 48'd35);

    // Back-to-back on the STEP=1 instance; multipliers all have bit 23 set
    pa[0] = 24'h123456; pb[0] = 24'h800001; pe[0] = 48'h091A2B123456;
    pa[1] = 24'h000003; pb[1] = 24'hC00000; pe[1] = 48'h000002400000;
    pa[2] = 24'h000010; pb[2] = 24'hFFFFFF; pe[2] = 48'h00000FFFFFF0;
    idx = 0; prev = 0;
    a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 1; t <= 200 && idx < 3; t++) begin
      @(posedge clk); #1;
      if (out_valid1) begin
        chk($sformatf("b2b result %0d", idx), result1, pe[idx]);
        chk($sformatf("b2b in_ready %0d", idx), in_ready1, 1'b1);
        if (idx == 0) chk("b2b first latency", t - 1, 24);
        else chk($sformatf("b2b period %0d", idx), t - prev, 25);
        prev = t;
        idx++;
        if (idx < 3) begin
          a = pa[idx]; b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b count", idx, 3);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of an operation
    a = 24'hFFFFFF; b = 24'hFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("midrst busy before", busy1, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst out_valid", {out_valid1, out_valid4}, 2'b00);
    chk("midrst busy", {busy1, busy4}, 2'b00);
    chk("midrst result", result1, 48'h0);
    chk("midrst in_ready", in_ready1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst idle after", {in_ready1, out_valid1, busy1}, 3'b100);
    transact(24'h000007, 24'h000009, 48'd63, "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
